// File: rtl/sram_checker.sv
// sram_checker
//   When the core reports halted, reads WORDS+1 consecutive SRAM words starting
//   at address 0. Words 0..WORDS-1 are summed (mod 2^32); word WORDS is the
//   reference. The check passes when (sum - 1) equals the reference. The
//   result is sticky until reset.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : asynchronous active-high reset
//   halted   : core-halted level; starts a check sequence from IDLE
//   rd_en    : SRAM read strobe
//   rd_addr  : SRAM word address (0 whenever rd_en is 0)
//   rd_data  : SRAM read data, valid the cycle after rd_en is sampled
//   busy     : sequence in progress (READ or CHECK)
//   done     : check complete (sticky)
//   pass     : sum - 1 matched the reference word (sticky)
//   fail     : complement of pass once done (sticky)
//   sum      : raw accumulated sum of words 0..WORDS-1
module sram_checker #(
    parameter int ADDR_W = 10,
    parameter int WORDS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halted,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [31:0]       sum
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CHECK,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;

    // One-cycle delayed copy of the read strobe/address: marks the edge at
    // which the SRAM's returned word is captured and which word it is.
    logic              cap_pend_q;
    logic [ADDR_W-1:0] cap_addr_q;

    logic [31:0] sum_d;
    logic [31:0] ref_q, ref_d;
    logic        done_d, pass_d;

    always_comb begin
        state_d   = state_q;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        sum_d     = sum;
        ref_d     = ref_q;
        done_d    = done;
        pass_d    = pass;

        case (state_q)
            IDLE: begin
                if (halted) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                    sum_d   = '0;
                    ref_d   = '0;
                end
            end

            READ: begin
                // Issue addresses back to back until LAST_ADDR has gone out.
                if (rd_en && (rd_addr != LAST_ADDR)) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr + ADDR_W'(1);
                end
                // rd_data is only looked at on a scheduled capture edge.
                if (cap_pend_q) begin
                    if (cap_addr_q == LAST_ADDR) begin
                        ref_d   = rd_data;
                        state_d = CHECK;
                    end else begin
                        sum_d = sum + rd_data;
                    end
                end
            end

            CHECK: begin
                state_d = DONE;
                done_d  = 1'b1;
                pass_d  = ((sum - 32'd1) == ref_q);
            end

            DONE: begin
                // Result held until reset; halted is ignored.
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            cap_pend_q <= 1'b0;
            cap_addr_q <= '0;
            sum        <= '0;
            ref_q      <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_en      <= rd_en_d;
            rd_addr    <= rd_addr_d;
            cap_pend_q <= rd_en;
            cap_addr_q <= rd_addr;
            sum        <= sum_d;
            ref_q      <= ref_d;
            done       <= done_d;
            pass       <= pass_d;
            fail       <= done_d & ~pass_d;
        end
    end

    always_comb begin
        busy = (state_q == READ) || (state_q == CHECK);
    end

endmodule

// File: tb/tb_sram_checker.sv
// tb_sram_checker
//   Directed bench for sram_checker with a behavioural SRAM responder.
//   Expected read addresses and expected final results are queued when a
//   sequence is started and popped as the DUT issues reads / reports done.
module tb_sram_checker;

    localparam int ADDR_W = 10;
    localparam int WORDS  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              halted;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic [31:0]       sum;

    sram_checker #(
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .halted  (halted),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .fail    (fail),
        .sum     (sum)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [2**ADDR_W];
    bit          xmode;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] sum;
        logic        pass;
    } result_t;

    int unsigned exp_addr_q [$];
    result_t     exp_res_q  [$];

    // SRAM model: data for a sampled read appears 1 time unit after the edge
    // and stays for that cycle; elsewhere the bus is X in xmode.
    always @(posedge clk) begin : sram_model
        logic              en_s;
        logic [ADDR_W-1:0] a_s;
        en_s = rd_en;
        a_s  = rd_addr;
        #1;
        if (en_s) rd_data = mem[a_s];
        else      rd_data = xmode ? 32'hxxxx_xxxx : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rd_en"},   32'(rd_en),   32'h0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'h0);
        chk({tag, "_busy"},    32'(busy),    32'h0);
        chk({tag, "_done"},    32'(done),    32'h0);
        chk({tag, "_pass"},    32'(pass),    32'h0);
        chk({tag, "_fail"},    32'(fail),    32'h0);
        chk({tag, "_sum"},     sum,          32'h0);
    endtask

    task automatic do_reset();
        halted = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        chk_zero_outputs("reset");
        rst = 1'b0;
        tick();
    endtask

    task automatic fill_mem(input logic [31:0] start, input logic [31:0] step,
                            input logic [31:0] ref_word);
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 32'h0;
        for (int i = 0; i < WORDS; i++) mem[i] = start + step * 32'(i);
        mem[WORDS] = ref_word;
    endtask

    task automatic push_expected();
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < WORDS; i++) s = s + mem[i];
        exp_res_q.push_back('{s, ((s - 32'd1) == mem[WORDS])});
    endtask

    // Starts (halted=1 before the next edge E0) and follows one sequence.
    // abort_at >= 0 asserts rst after edge E0+abort_at for 3 cycles.
    task automatic do_seq(input bit pulse, input int abort_at, output bit aborted);
        result_t     r;
        int unsigned a;
        aborted = 1'b0;
        exp_addr_q.delete();
        for (int i = 0; i <= WORDS; i++) exp_addr_q.push_back(i);
        halted = 1'b1;
        tick();
        for (int k = 0; k <= WORDS + 3; k++) begin
            if (k > 0) tick();
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk_zero_outputs("abort");
                repeat (3) @(posedge clk);
                #1;
                rst     = 1'b0;
                aborted = 1'b1;
                return;
            end
            chk("rd_en", 32'(rd_en), (k <= WORDS) ? 32'h1 : 32'h0);
            if (rd_en) begin
                if (exp_addr_q.size() == 0) begin
                    chk("extra_read", 32'(rd_addr), 32'hFFFF_FFFF);
                end else begin
                    a = exp_addr_q.pop_front();
                    chk("rd_addr", 32'(rd_addr), 32'(a));
                end
            end else begin
                chk("rd_addr_idle", 32'(rd_addr), 32'h0);
            end
            chk("busy", 32'(busy), (k <= WORDS + 2) ? 32'h1 : 32'h0);
            if (k < WORDS + 3) begin
                chk("done_early", 32'(done), 32'h0);
            end else begin
                if (exp_res_q.size() == 0) begin
                    chk("result_queue", 32'h0, 32'h1);
                end else begin
                    r = exp_res_q.pop_front();
                    chk("done", 32'(done), 32'h1);
                    chk("pass", 32'(pass), 32'(r.pass));
                    chk("fail", 32'(fail), 32'(!r.pass));
                    chk("sum",  sum, r.sum);
                end
            end
            if (k == 0 && pulse) halted = 1'b0;
        end
        chk("reads_outstanding", 32'(exp_addr_q.size()), 32'h0);
    endtask

    initial begin : stimulus
        bit          ab;
        logic [31:0] held_sum;
        rst     = 1'b1;
        halted  = 1'b0;
        xmode   = 1'b0;
        rd_data = 32'h0;
        fill_mem(32'd1, 32'd1, 32'd135);

        do_reset();

        // idle with halted low: no reads, no activity
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_rd_en", 32'(rd_en), 32'h0);
            chk("idle_busy",  32'(busy),  32'h0);
            chk("idle_done",  32'(done),  32'h0);
        end

        // words 1..16, reference 135 -> pass
        fill_mem(32'd1, 32'd1, 32'd135);
        push_expected();
        do_seq(1'b0, -1, ab);
        // DONE ignores halted and holds its result
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_done",  32'(done),  32'h1);
            chk("hold_rd_en", 32'(rd_en), 32'h0);
            chk("hold_sum",   sum,        32'd136);
        end

        // reference 136 -> fail
        do_reset();
        fill_mem(32'd1, 32'd1, 32'd136);
        push_expected();
        do_seq(1'b0, -1, ab);

        // wrap-around: sixteen 0xFFFFFFFF words
        do_reset();
        fill_mem(32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFEF);
        push_expected();
        do_seq(1'b0, -1, ab);
        chk("wrap_sum", sum, 32'hFFFF_FFF0);

        // single-cycle halted pulse, then a later pulse starts nothing
        do_reset();
        fill_mem(32'd1, 32'd1, 32'd135);
        push_expected();
        do_seq(1'b1, -1, ab);
        held_sum = sum;
        halted = 1'b1;
        tick();
        halted = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("late_pulse_rd_en", 32'(rd_en), 32'h0);
            chk("late_pulse_done",  32'(done),  32'h1);
            chk("late_pulse_sum",   sum,        held_sum);
        end

        // reset mid-READ, halted held high: restart from address 0
        do_reset();
        fill_mem(32'd1, 32'd1, 32'd135);
        push_expected();
        do_seq(1'b0, 8, ab);
        chk("aborted", 32'(ab), 32'h1);
        do_seq(1'b0, -1, ab);

        // rd_data X outside capture cycles
        do_reset();
        xmode = 1'b1;
        fill_mem(32'd1, 32'd1, 32'd135);
        push_expected();
        do_seq(1'b0, -1, ab);
        xmode = 1'b0;

        chk("results_outstanding", 32'(exp_res_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_checker.md
SRAM_CHECKER -- requirements
Module: sram_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the SRAM word-address width.
REQ-002 SHALL have parameter WORDS, default 16, meaning the number of result words summed; legal range 1..2^ADDR_W-1.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port halted  input  1  core-halted indication, level-sensitive.
REQ-006 SHALL have port rd_en  output  1  SRAM read strobe.
REQ-007 SHALL have port rd_addr  output  ADDR_W  SRAM word address.
REQ-008 SHALL have port rd_data  input  32  SRAM read data; valid during the cycle after the edge that samples rd_en=1.
REQ-009 SHALL have port busy  output  1  check sequence in progress.
REQ-010 SHALL have port done  output  1  check complete, sticky.
REQ-011 SHALL have port pass  output  1  sum(words 0..WORDS-1) - 1 == word WORDS, sticky.
REQ-012 SHALL have port fail  output  1  mismatch, sticky; fail is the complement of pass whenever done=1.
REQ-013 SHALL have port sum  output  32  running/final accumulated sum minus nothing (raw sum).

Function
REQ-014 SHALL implement FSM states IDLE, READ, CHECK, DONE.
REQ-015 In IDLE, halted sampled 1 at edge E0 SHALL move to READ with rd_en=1, rd_addr=0.
REQ-016 In READ, rd_en SHALL stay 1 for WORDS+1 consecutive cycles, with rd_addr stepping 0,1,...,WORDS, one per cycle, no gaps.
REQ-017 rd_data for address n SHALL be captured on the edge following the cycle in which the SRAM returns it (edge E0+n+2).
REQ-018 Captured words 0..WORDS-1 SHALL be added to sum modulo 2^32; word WORDS SHALL be held as the reference value and not added.
REQ-019 After the address-WORDS capture (edge E0+WORDS+2), the FSM SHALL enter CHECK; rd_en SHALL be 0 from edge E0+WORDS+2 onward.
REQ-020 CHECK SHALL compare (sum - 1) mod 2^32 against the reference value; at edge E0+WORDS+3, the FSM SHALL enter DONE with done=1 and pass/fail registered.
REQ-021 DONE SHALL hold done/pass/fail/sum constant until reset, ignoring halted.
REQ-022 busy SHALL be 1 in READ and CHECK, and 0 in IDLE and DONE.
REQ-023 halted deasserting during READ/CHECK SHALL be ignored; the sequence completes.
REQ-024 rd_data SHALL be ignored in any cycle where no capture is scheduled, including when its value is X.
REQ-025 rd_addr SHALL hold 0 whenever rd_en=0.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, with rd_en=0, rd_addr=0, busy=0, done=0, pass=0, fail=0, sum=0, and the reference register at 0.
REQ-027 rst asserted mid-READ or mid-CHECK SHALL abort the sequence; after release, the block SHALL restart from address 0 on the next sampled halted=1.
REQ-028 With rst=0 and halted=0, the block SHALL stay in IDLE indefinitely with no reads issued.

Verification
REQ-029 WORDS=16; words 0..15 = 1..16, word 16 = 135; halted=1 at E0 -> rd_en high for 17 cycles with addr 0..16, sum=136, and done=1, pass=1, fail=0 at E0+19.
REQ-030 Same data but word 16 = 136 -> done=1, pass=0, fail=1 at E0+19, sum=136.
REQ-031 All words 0..15 = 0xFFFFFFFF, word 16 = 0xFFFFFFEF -> sum=0xFFFFFFF0 (wrap) and pass=1.
REQ-032 halted pulsed for 1 cycle only -> full 17-read sequence still completes; done=1 at E0+19; a later halted pulse causes no new reads.
REQ-033 rst asserted at E0+8, released 3 cycles later, halted held 1 -> outputs 0 during reset; new sequence starts at addr 0; correct pass result 19 edges after restart.
REQ-034 rd_data driven X except in capture cycles -> identical results to REQ-029.
